// File: rtl/nf_pwm_pkg.sv
// Shared types and constants for the PWM dead-time output stage and its bus-side register map.
package nf_pwm_pkg;

  localparam int NF_DT_WIDTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    DT_TO_H = 3'd1,
    H_ON    = 3'd2,
    DT_TO_L = 3'd3,
    L_ON    = 3'd4
  } nf_dt_state_t;

endpackage

// File: rtl/nf_pwm_deadtime.sv
// Complementary high/low drive generator with programmable dead time and
// a sticky flag for PWM pulses that are shorter than the dead time.
module nf_pwm_deadtime
  import nf_pwm_pkg::*;
#(
  parameter int dt_width = NF_DT_WIDTH_DEFAULT
) (
  input  logic                pwm_clk,
  input  logic                pwm_resetn,
  input  logic                en,
  input  logic [dt_width-1:0] dt,
  input  logic                pwm_in,
  output logic                pwm_h,
  output logic                pwm_l,
  output logic                dt_busy,
  output logic                short_pulse
);

  localparam logic [dt_width-1:0] cnt_zero = {dt_width{1'b0}};
  localparam logic [dt_width-1:0] cnt_one  = {{(dt_width-1){1'b0}}, 1'b1};

  nf_dt_state_t        state_r;
  nf_dt_state_t        state_s;
  logic [dt_width-1:0] cnt_r;
  logic [dt_width-1:0] cnt_s;
  logic                short_s;
  logic                pwm_q;
  logic                dt_nonzero_s;

  assign dt_nonzero_s = (dt != cnt_zero);

  // Input capture: the FSM only ever looks at the registered copy of pwm_in.
  always_ff @(posedge pwm_clk or negedge pwm_resetn) begin
    if (!pwm_resetn) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= pwm_in;
    end
  end

  // Next-state, counter and sticky-flag decode.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    short_s = short_pulse;
    if (!en) begin
      state_s = OFF;
      cnt_s   = cnt_zero;
      short_s = 1'b0;
    end else begin
      case (state_r)
        OFF: begin
          if (dt_nonzero_s) begin
            state_s = pwm_q ? DT_TO_H : DT_TO_L;
            cnt_s   = dt - cnt_one;
          end else begin
            state_s = pwm_q ? H_ON : L_ON;
          end
        end
        H_ON: begin
          if (!pwm_q) begin
            if (dt_nonzero_s) begin
              state_s = DT_TO_L;
              cnt_s   = dt - cnt_one;
            end else begin
              state_s = L_ON;
            end
          end else begin
            state_s = H_ON;
          end
        end
        L_ON: begin
          if (pwm_q) begin
            if (dt_nonzero_s) begin
              state_s = DT_TO_H;
              cnt_s   = dt - cnt_one;
            end else begin
              state_s = H_ON;
            end
          end else begin
            state_s = L_ON;
          end
        end
        // A reversal inside the dead time returns to the side that was on;
        // the other side was never driven, so no overlap can occur.
        DT_TO_L: begin
          if (pwm_q) begin
            state_s = H_ON;
            cnt_s   = cnt_zero;
            short_s = 1'b1;
          end else if (cnt_r != cnt_zero) begin
            cnt_s = cnt_r - cnt_one;
          end else begin
            state_s = L_ON;
          end
        end
        DT_TO_H: begin
          if (!pwm_q) begin
            state_s = L_ON;
            cnt_s   = cnt_zero;
            short_s = 1'b1;
          end else if (cnt_r != cnt_zero) begin
            cnt_s = cnt_r - cnt_one;
          end else begin
            state_s = H_ON;
          end
        end
        default: begin
          state_s = OFF;
          cnt_s   = cnt_zero;
        end
      endcase
    end
  end

  // State, counter and outputs; outputs decode from next state so they are glitch-free flops.
  always_ff @(posedge pwm_clk or negedge pwm_resetn) begin
    if (!pwm_resetn) begin
      state_r     <= OFF;
      cnt_r       <= cnt_zero;
      pwm_h       <= 1'b0;
      pwm_l       <= 1'b0;
      dt_busy     <= 1'b0;
      short_pulse <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      pwm_h       <= (state_s == H_ON);
      pwm_l       <= (state_s == L_ON);
      dt_busy     <= (state_s == DT_TO_H) || (state_s == DT_TO_L);
      short_pulse <= short_s;
    end
  end

endmodule

// File: tb/tb_nf_pwm_deadtime.sv
// Self-checking bench for nf_pwm_deadtime: per-cycle vector table through a
// scoreboard queue, plus hand-written async-reset and maximum dead-time sequences.
module tb_nf_pwm_deadtime;

  logic       pwm_clk;
  logic       pwm_resetn;
  logic       en;
  logic [7:0] dt;
  logic       pwm_in;
  logic       pwm_h;
  logic       pwm_l;
  logic       dt_busy;
  logic       short_pulse;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic       en;
    logic [7:0] dt;
    logic       pin;
    logic       h;
    logic       l;
    logic       busy;
    logic       sp;
  } vec_t;

  typedef struct packed {
    logic h;
    logic l;
    logic busy;
    logic sp;
  } exp_t;

  vec_t vecs[31];
  exp_t sb_q[$];

  nf_pwm_deadtime #(.dt_width(8)) dut (
    .pwm_clk     (pwm_clk),
    .pwm_resetn  (pwm_resetn),
    .en          (en),
    .dt          (dt),
    .pwm_in      (pwm_in),
    .pwm_h       (pwm_h),
    .pwm_l       (pwm_l),
    .dt_busy     (dt_busy),
    .short_pulse (short_pulse)
  );

  initial pwm_clk = 1'b0;
  always #5 pwm_clk = ~pwm_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_overlap();
    chk("no_overlap", {31'd0, pwm_h & pwm_l}, 32'd0);
  endtask

  // Drives one row, pushes its expectation, then pops and compares after the edge.
  task automatic apply(input int idx);
    exp_t e;
    en     = vecs[idx].en;
    dt     = vecs[idx].dt;
    pwm_in = vecs[idx].pin;
    sb_q.push_back('{vecs[idx].h, vecs[idx].l, vecs[idx].busy, vecs[idx].sp});
    @(posedge pwm_clk);
    @(negedge pwm_clk);
    e = sb_q.pop_front();
    chk($sformatf("row%0d_h", idx), {31'd0, pwm_h}, {31'd0, e.h});
    chk($sformatf("row%0d_l", idx), {31'd0, pwm_l}, {31'd0, e.l});
    chk($sformatf("row%0d_busy", idx), {31'd0, dt_busy}, {31'd0, e.busy});
    chk($sformatf("row%0d_sp", idx), {31'd0, short_pulse}, {31'd0, e.sp});
  endtask

  initial begin
    int n;
    // en, dt, pwm_in, expected h, l, busy, short_pulse after that edge
    // enable with dt=3 and pwm low: three dead-time cycles, then low side on
    vecs[0]  = '{1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    // rising edge with dt=4: low falls at E1, high rises at E5
    vecs[6]  = '{1'b1, 8'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 8'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 8'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 8'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 8'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    // short low pulse with dt=8: abort back to high, sticky flag
    vecs[12] = '{1'b1, 8'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 8'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 8'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 8'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 8'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 8'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{1'b1, 8'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 8'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    // zero dead time: drives swap on the same edge
    vecs[20] = '{1'b1, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[23] = '{1'b1, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[24] = '{1'b1, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[25] = '{1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[26] = '{1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    // disable in the middle of DT_TO_H
    vecs[27] = '{1'b1, 8'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[28] = '{1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[29] = '{1'b0, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[30] = '{1'b1, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    pwm_resetn = 1'b0;
    en         = 1'b0;
    dt         = 8'd3;
    pwm_in     = 1'b0;
    @(negedge pwm_clk);
    @(negedge pwm_clk);
    chk("reset_h", {31'd0, pwm_h}, 32'd0);
    chk("reset_l", {31'd0, pwm_l}, 32'd0);
    chk("reset_busy", {31'd0, dt_busy}, 32'd0);
    chk("reset_sp", {31'd0, short_pulse}, 32'd0);
    pwm_resetn = 1'b1;

    for (int i = 0; i < 31; i++) begin
      apply(i);
      chk_overlap();
    end
    chk("scoreboard_empty", sb_q.size(), 32'd0);

    // async reset while the high side is on, well away from any clock edge
    chk("pre_reset_h", {31'd0, pwm_h}, 32'd1);
    #2;
    pwm_resetn = 1'b0;
    #1;
    chk("async_reset_h", {31'd0, pwm_h}, 32'd0);
    chk("async_reset_l", {31'd0, pwm_l}, 32'd0);
    @(negedge pwm_clk);
    pwm_resetn = 1'b1;

    // maximum dead time, with dt reprogrammed mid-interval
    en     = 1'b1;
    dt     = 8'd0;
    pwm_in = 1'b0;
    @(posedge pwm_clk);
    @(negedge pwm_clk);
    chk("max_start_l", {31'd0, pwm_l}, 32'd1);
    dt     = 8'd255;
    pwm_in = 1'b1;
    @(posedge pwm_clk);
    @(negedge pwm_clk);
    chk("max_e0_l", {31'd0, pwm_l}, 32'd1);
    n = 0;
    for (int i = 0; i < 400 && !pwm_h; i++) begin
      @(posedge pwm_clk);
      @(negedge pwm_clk);
      chk_overlap();
      if (!pwm_h && !pwm_l) n++;
      if (n == 10) dt = 8'd2;
    end
    chk("max_dt_low_cycles", n, 32'd255);
    chk("max_dt_h_on", {31'd0, pwm_h}, 32'd1);

    pwm_in = 1'b0;
    @(posedge pwm_clk);
    @(negedge pwm_clk);
    chk("new_dt_e0_h", {31'd0, pwm_h}, 32'd1);
    n = 0;
    for (int i = 0; i < 40 && !pwm_l; i++) begin
      @(posedge pwm_clk);
      @(negedge pwm_clk);
      chk_overlap();
      if (!pwm_h && !pwm_l) n++;
    end
    chk("new_dt_low_cycles", n, 32'd2);
    chk("new_dt_l_on", {31'd0, pwm_l}, 32'd1);
    chk("no_short_flag", {31'd0, short_pulse}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
